// File: rtl/hp_round_pack_if.sv
// Valid/ready bundle between the multiplier core and the round/pack stage.
// The slave side is the round/pack block; the master side feeds and drains it.
interface hp_round_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [5:0]  in_exp_sum;
  logic [21:0] in_prod;
  logic        in_zero;
  logic        in_invalid;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_product;
  logic [1:0]  out_exc;

  modport slave (
    input  in_valid,
    input  in_sign,
    input  in_exp_sum,
    input  in_prod,
    input  in_zero,
    input  in_invalid,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_product,
    output out_exc
  );

  modport master (
    output in_valid,
    output in_sign,
    output in_exp_sum,
    output in_prod,
    output in_zero,
    output in_invalid,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_product,
    input  out_exc
  );
endinterface

// File: rtl/hp_round_pack.sv
// Half-precision multiplier back end: normalize, round-to-nearest-even,
// pack binary16 with a 2-bit exception code and a saturating exception count.
module hp_round_pack #(
  parameter int BIAS  = 15,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  hp_round_pack_if.slave   bus,
  output logic [CNT_W-1:0] exc_count
);

  typedef struct packed {
    logic              sign;
    logic              zero;
    logic              invalid;
    logic [9:0]        mant;
    logic              g;
    logic              s;
    logic signed [7:0] e;
  } norm_t;

  localparam logic signed [7:0] BIAS_E = 8'(BIAS);

  logic        en;
  logic        s1_valid;
  norm_t       s1;
  norm_t       n_d;
  logic        ov_q;
  logic [15:0] op_q;
  logic [1:0]  oe_q;

  assign en           = !ov_q || bus.out_ready;
  assign bus.in_ready = en;
  assign bus.out_valid   = ov_q;
  assign bus.out_product = op_q;
  assign bus.out_exc     = oe_q;

  logic signed [7:0] e_raw;
  assign e_raw = $signed({2'b00, bus.in_exp_sum}) - BIAS_E;

  always_comb begin
    n_d         = '0;
    n_d.sign    = bus.in_sign;
    n_d.zero    = bus.in_zero;
    n_d.invalid = bus.in_invalid;
    if (bus.in_prod[21]) begin
      n_d.mant = bus.in_prod[20:11];
      n_d.g    = bus.in_prod[10];
      n_d.s    = |bus.in_prod[9:0];
      n_d.e    = e_raw + 8'sd1;
    end else begin
      n_d.mant = bus.in_prod[19:10];
      n_d.g    = bus.in_prod[9];
      n_d.s    = |bus.in_prod[8:0];
      n_d.e    = e_raw;
    end
  end

  logic              inc;
  logic [10:0]       mant_r;
  logic signed [7:0] e_r;
  logic [15:0]       prod_d;
  logic [1:0]        exc_d;

  // A carry out of the mantissa leaves mant_r[9:0] at zero, bumping e.
  always_comb begin
    inc    = s1.g & (s1.s | s1.mant[0]);
    mant_r = {1'b0, s1.mant} + {10'd0, inc};
    e_r    = s1.e + (mant_r[10] ? 8'sd1 : 8'sd0);
    prod_d = {s1.sign, e_r[4:0], mant_r[9:0]};
    exc_d  = 2'b00;
    if (s1.invalid) begin
      prod_d = 16'h7E00;
      exc_d  = 2'b11;
    end else if (s1.zero) begin
      prod_d = {s1.sign, 15'b0};
    end else if (e_r >= 8'sd31) begin
      prod_d = {s1.sign, 5'h1F, 10'h0};
      exc_d  = 2'b01;
    end else if (e_r <= 8'sd0) begin
      prod_d = {s1.sign, 15'b0};
      exc_d  = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
      ov_q     <= 1'b0;
      op_q     <= '0;
      oe_q     <= '0;
    end else if (en) begin
      s1_valid <= bus.in_valid;
      s1       <= n_d;
      ov_q     <= s1_valid;
      op_q     <= prod_d;
      oe_q     <= exc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exc_count <= '0;
    end else if (ov_q && bus.out_ready &&
                 oe_q != 2'b00 && exc_count != '1) begin
      exc_count <= exc_count + 1'b1;
    end
  end

endmodule

// File: doc/hp_round_pack.md
Name: hp_round_pack

Overview:
- Downstream stage of the half-precision multiplier datapath.
- Consumes the raw 22-bit significand product (1.mA × 1.mB), the product sign, the raw exponent sum and pre-detected operand flags.
- Normalizes, rounds to nearest-even and packs an IEEE-754 binary16 result with the team's 2-bit exception code.
- Two-stage pipeline with a valid/ready handshake on both sides, plus a saturating exception counter for status.

Parameters:
- BIAS, 15, exponent bias subtracted from the raw exponent sum.
- CNT_W, 8, width of the saturating exception counter.

Ports:
- clk  input  1  rising-edge clock (sole clock).
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage accepts a beat this cycle.
- in_sign  input  1  signA XOR signB.
- in_exp_sum  input  6  expA + expB, unbiased raw sum, 2..60.
- in_prod  input  22  unsigned significand product; in_prod[21] or in_prod[20] is set.
- in_zero  input  1  an operand is exactly zero.
- in_invalid  input  1  an operand is inf, NaN or denormal.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_product  output  16  packed binary16 result.
- out_exc  output  2  exception code: 00 valid, 01 overflow, 10 underflow, 11 invalid input.
- exc_count  output  CNT_W  saturating count of results with out_exc != 00 since reset.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - out_valid=0, out_product=0, out_exc=00, exc_count=0, both stage valid bits=0.
  - Reset mid-operation discards all in-flight beats; no partial output is produced.
- Handshake:
  - en = !out_valid | out_ready; in_ready = en (combinational).
  - A beat transfers on in_valid & in_ready; a result transfers on out_valid & out_ready.
  - When en=0, both stages hold their contents; out_product and out_exc stay stable while out_valid=1 and out_ready=0.
  - No bubble collapsing: if stage 1 is empty and the output is stalled, in_ready is still 0.
- Latency: 2 cycles from input acceptance to out_valid with out_ready held high. Throughput is 1 beat per cycle.
- Stage 1 (normalize):
  - If in_prod[21]=1: mant=in_prod[20:11], g=in_prod[10], s=|in_prod[9:0], e=in_exp_sum-BIAS+1.
  - Else: mant=in_prod[19:10], g=in_prod[9], s=|in_prod[8:0], e=in_exp_sum-BIAS.
  - e is a signed 8-bit value.
  - Register mant, g, s, e, sign, zero and invalid.
- Stage 2 (round/pack), RNE:
  - inc = g & (s | mant[0]).
  - If mant=10'h3FF and inc=1: mant becomes 0 and e becomes e+1.
  - Priority, highest first:
    - invalid: product 16'h7E00, exc 11.
    - zero: product {sign,15'b0}, exc 00.
    - e>=31: product {sign,5'h1F,10'h0}, exc 01.
    - e<=0: product {sign,15'b0}, exc 10 (flush, no denormals).
    - otherwise: product {sign,e[4:0],mant}, exc 00.
  - The overflow check uses e after the rounding carry.
- exc_count:
  - Increments by 1 on each output transfer with out_exc != 00.
  - Saturates at all-ones and never wraps.
  - A transfer coinciding with rst is not counted.

Test Plan:
- 5×6: in_prod=22'h1E0000, exp_sum=34, sign=0, out_ready=1 → out_product=16'h4F80 (30.0), exc 00, out_valid exactly 2 cycles after acceptance.
- 3×3 (normalize shift): in_prod=22'h240000, exp_sum=32 → 16'h4880 (9.0), exc 00.
- Rounding, all with exp_sum=30:
  - in_prod=22'h100600 → mant 0x002 (round up).
  - in_prod=22'h100200 → mant 0x000 (tie to even).
  - in_prod=22'h1FFE00 → 16'h4000 (mantissa carry into exponent).
- Exceptions:
  - exp_sum=45 with in_prod[21]=1 → 16'h7C00, exc 01.
  - exp_sum=15 with in_prod=22'h100000 → 16'h0000, exc 10.
  - in_invalid=1 → 16'h7E00, exc 11.
  - in_zero=1, sign=1 → 16'h8000, exc 00.
  - After these four beats, exc_count=3.
- Backpressure:
  - Stream 4 beats with out_ready low for 3 cycles mid-stream → in_ready=0 while stalled, outputs held stable, all 4 results delivered in order with none lost or duplicated.
- Reset mid-stream:
  - Assert rst with both stages full → next cycle out_valid=0 and exc_count=0.
  - 260 overflow beats → exc_count saturates at 255.
